// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage.
// Contents:
//   DATA_WIDTH      - default data/address width
//   REG_ADDR_WIDTH  - register-file address width
//   state_t         - MEM stage access FSM encoding
//   is_word_aligned - word-alignment test on the low address bits
package mips_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // A word access is legal only when the two low address bits are zero.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load/bubble select.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   i_load            - 1: capture the inputs, 0: insert a bubble (all zero)
//   i_alu_result      - ALU result forwarded to writeback
//   i_read_data       - data returned by memory (0 when none)
//   i_mem_to_reg      - writeback source select
//   i_reg_write       - register-file write enable
//   i_write_register  - destination register
//   o_*               - registered copies of the above
module mem_wb_reg #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_load,
  input  logic [DATA_WIDTH-1:0]               i_alu_result,
  input  logic [DATA_WIDTH-1:0]               i_read_data,
  input  logic                                i_mem_to_reg,
  input  logic                                i_reg_write,
  input  logic [mips_pkg::REG_ADDR_WIDTH-1:0] i_write_register,
  output logic [DATA_WIDTH-1:0]               o_alu_result,
  output logic [DATA_WIDTH-1:0]               o_read_data,
  output logic                                o_mem_to_reg,
  output logic                                o_reg_write,
  output logic [mips_pkg::REG_ADDR_WIDTH-1:0] o_write_register
);

  // Pipeline register: load a real instruction or clear to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_alu_result     <= '0;
      o_read_data      <= '0;
      o_mem_to_reg     <= 1'b0;
      o_reg_write      <= 1'b0;
      o_write_register <= '0;
    end else if (i_load) begin
      o_alu_result     <= i_alu_result;
      o_read_data      <= i_read_data;
      o_mem_to_reg     <= i_mem_to_reg;
      o_reg_write      <= i_reg_write;
      o_write_register <= i_write_register;
    end else begin
      // A bubble has no side effects in WB; zeroing the data fields too
      // keeps the register contents deterministic.
      o_alu_result     <= '0;
      o_read_data      <= '0;
      o_mem_to_reg     <= 1'b0;
      o_reg_write      <= 1'b0;
      o_write_register <= '0;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller of the 5-stage MIPS pipeline.
// Resolves branches, runs a req/ack handshake with a multi-cycle data memory
// (with timeout), stalls upstream while an access is outstanding and owns the
// MEM/WB register.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   *_MEM inputs                    - EX/MEM register outputs
//   PCSrc_MEM, Jump_taken_MEM       - combinational branch/jump resolution
//   Stall_MEM                       - hold PC, IF/ID, ID/EX, EX/MEM when high
//   mem_req/we/addr/wdata           - registered memory request
//   mem_ack, mem_rdata              - memory completion pulse and read data
//   *_WB outputs                    - MEM/WB register
//   mem_error, align_error          - sticky timeout / misalignment flags
module mem_stage_ctrl #(
  parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               ALU_result_MEM,
  input  logic [DATA_WIDTH-1:0]               Read_Data_2_MEM,
  input  logic                                BranchEQ_MEM,
  input  logic                                BranchNE_MEM,
  input  logic                                Jump_MEM,
  input  logic                                Zero_MEM,
  input  logic                                MemRead_MEM,
  input  logic                                MemWrite_MEM,
  input  logic                                MemToReg_MEM,
  input  logic                                RegWrite_MEM,
  input  logic [mips_pkg::REG_ADDR_WIDTH-1:0] Write_register_MEM,
  output logic                                PCSrc_MEM,
  output logic                                Jump_taken_MEM,
  output logic                                Stall_MEM,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [DATA_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic                                mem_ack,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic [DATA_WIDTH-1:0]               Read_Data_WB,
  output logic [DATA_WIDTH-1:0]               ALU_result_WB,
  output logic                                MemToReg_WB,
  output logic                                RegWrite_WB,
  output logic [mips_pkg::REG_ADDR_WIDTH-1:0] Write_register_WB,
  output logic                                mem_error,
  output logic                                align_error
);

  import mips_pkg::*;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_kill;
  logic                  r_mem_error;
  logic                  r_align_error;

  logic                  w_pending;
  logic                  w_aligned;
  logic                  w_stall;
  logic                  w_wb_load;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_wb_rdata;
  logic                  w_wb_reg_write;

  assign w_pending = MemRead_MEM | MemWrite_MEM;
  assign w_aligned = is_word_aligned(ALU_result_MEM[1:0]);

  assign PCSrc_MEM      = (BranchEQ_MEM & Zero_MEM) | (BranchNE_MEM & ~Zero_MEM);
  assign Jump_taken_MEM = Jump_MEM;
  assign Stall_MEM      = w_stall;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_error      = r_mem_error;
  assign align_error    = r_align_error;

  // Next-state, stall and MEM/WB load decisions.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_wb_load    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pending) begin
          // Misaligned accesses also stall one cycle so the instruction is
          // still presented when DONE retires it.
          w_stall = 1'b1;
          if (w_aligned) begin
            w_next_state = ACCESS;
          end else begin
            w_next_state = DONE;
          end
        end else begin
          w_wb_load = 1'b1;
        end
      end
      ACCESS: begin
        w_stall = 1'b1;
        // Ack is tested first so an ack on the last allowed cycle wins.
        if (mem_ack) begin
          w_next_state = DONE;
        end else if (r_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end else begin
          w_next_state = ACCESS;
        end
      end
      DONE: begin
        w_wb_load    = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Data and write-enable presented to MEM/WB: captured data only on DONE.
  always_comb begin
    w_wb_rdata     = '0;
    w_wb_reg_write = RegWrite_MEM;
    if (r_state == DONE) begin
      w_wb_rdata     = r_rdata;
      w_wb_reg_write = RegWrite_MEM & ~r_kill;
    end else begin
      w_wb_rdata     = '0;
      w_wb_reg_write = RegWrite_MEM;
    end
  end

  // FSM state, timeout counter, memory request and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_rdata       <= '0;
      r_kill        <= 1'b0;
      r_mem_error   <= 1'b0;
      r_align_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pending) begin
            r_rdata <= '0;
            r_kill  <= ~w_aligned;
            if (w_aligned) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= MemWrite_MEM;
              r_mem_addr  <= ALU_result_MEM;
              r_mem_wdata <= Read_Data_2_MEM;
            end else begin
              r_align_error <= 1'b1;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            // Writes (including read+write) leave the captured data at 0.
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_error <= 1'b1;
          end
        end
        DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  mem_wb_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_wb_reg (
    .clk              (clk),
    .reset            (reset),
    .i_load           (w_wb_load),
    .i_alu_result     (ALU_result_MEM),
    .i_read_data      (w_wb_rdata),
    .i_mem_to_reg     (MemToReg_MEM),
    .i_reg_write      (w_wb_reg_write),
    .i_write_register (Write_register_MEM),
    .o_alu_result     (ALU_result_WB),
    .o_read_data      (Read_Data_WB),
    .o_mem_to_reg     (MemToReg_WB),
    .o_reg_write      (RegWrite_WB),
    .o_write_register (Write_register_WB)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, branch
// table, reset-in-ACCESS sequence and randomized instructions checked
// against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_result_MEM, Read_Data_2_MEM;
  logic        BranchEQ_MEM, BranchNE_MEM, Jump_MEM, Zero_MEM;
  logic        MemRead_MEM, MemWrite_MEM, MemToReg_MEM, RegWrite_MEM;
  logic [4:0]  Write_register_MEM;
  logic        PCSrc_MEM, Jump_taken_MEM, Stall_MEM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] Read_Data_WB, ALU_result_WB;
  logic        MemToReg_WB, RegWrite_WB;
  logic [4:0]  Write_register_WB;
  logic        mem_error, align_error;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TIMEOUT), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .ALU_result_MEM(ALU_result_MEM), .Read_Data_2_MEM(Read_Data_2_MEM),
    .BranchEQ_MEM(BranchEQ_MEM), .BranchNE_MEM(BranchNE_MEM),
    .Jump_MEM(Jump_MEM), .Zero_MEM(Zero_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .MemToReg_MEM(MemToReg_MEM), .RegWrite_MEM(RegWrite_MEM),
    .Write_register_MEM(Write_register_MEM),
    .PCSrc_MEM(PCSrc_MEM), .Jump_taken_MEM(Jump_taken_MEM), .Stall_MEM(Stall_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .Read_Data_WB(Read_Data_WB), .ALU_result_WB(ALU_result_WB),
    .MemToReg_WB(MemToReg_WB), .RegWrite_WB(RegWrite_WB),
    .Write_register_WB(Write_register_WB),
    .mem_error(mem_error), .align_error(align_error)
  );

  // One instruction plus memory behaviour and the expected outcome.
  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        rw;
    logic [4:0]  wr;
    int          lat;      // ack on this ACCESS cycle (1-based), 0 = never
    logic [31:0] rd;
    int          e_stall;
    int          e_acc;
    logic [31:0] e_rdata;
    logic        e_rw;
    logic        e_merr;
    logic        e_aerr;
  } vec_t;

  typedef struct {
    logic beq; logic bne; logic zero; logic jmp; logic e_pc; logic e_j;
  } br_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic sticky_merr = 1'b0;
  logic sticky_aerr = 1'b0;
  vec_t tbl[8];
  br_t  btbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ALU_result_MEM     = v.alu;
    Read_Data_2_MEM    = v.wd;
    MemRead_MEM        = v.mr;
    MemWrite_MEM       = v.mw;
    MemToReg_MEM       = v.mtr;
    RegWrite_MEM       = v.rw;
    Write_register_MEM = v.wr;
  endtask

  // Transaction-level expectation derived from the instruction and the
  // memory latency: how long it stalls and what reaches writeback.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    bit   is_acc, mis, acked;
    e      = v;
    is_acc = v.mr | v.mw;
    mis    = is_acc && (v.alu[1:0] != 2'b00);
    acked  = is_acc && !mis && (v.lat >= 1) && (v.lat <= TIMEOUT);
    e.e_acc   = (!is_acc || mis) ? 0 : (acked ? v.lat : TIMEOUT);
    e.e_stall = !is_acc ? 0 : (mis ? 1 : 1 + e.e_acc);
    e.e_rdata = (acked && v.mr && !v.mw) ? v.rd : 32'h0;
    e.e_rw    = mis ? 1'b0 : v.rw;
    e.e_merr  = sticky_merr | (is_acc && !mis && !acked);
    e.e_aerr  = sticky_aerr | mis;
    return e;
  endfunction

  // Present one instruction at posedge+1, play the memory, check retirement.
  task automatic run_instr(input vec_t v, input string tag);
    int stalls = 0;
    int acc = 0;
    int bad_bub = 0;
    int bad_req = 0;
    bit done = 0;
    logic req_at_done;
    drive(v);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!Stall_MEM) begin
        done = 1;
      end else begin
        stalls++;
        if (stalls > 1 && (RegWrite_WB !== 1'b0 || MemToReg_WB !== 1'b0)) bad_bub++;
        if (mem_req === 1'b1) begin
          acc++;
          if (acc == 1 && (mem_addr !== v.alu || mem_we !== v.mw || mem_wdata !== v.wd))
            bad_req++;
          mem_ack   = (acc == v.lat);
          mem_rdata = (acc == v.lat) ? v.rd : $urandom;
        end else begin
          mem_ack = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    chk($sformatf("%s_bound", tag), 32'(done), 32'd1);
    req_at_done = mem_req;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s_stall", tag), stalls, v.e_stall);
    chk($sformatf("%s_acc", tag), acc, v.e_acc);
    chk($sformatf("%s_bubble", tag), bad_bub, 0);
    chk($sformatf("%s_reqfields", tag), bad_req, 0);
    chk($sformatf("%s_reqdrop", tag), 32'(req_at_done), 32'd0);
    chk($sformatf("%s_alu_wb", tag), ALU_result_WB, v.alu);
    chk($sformatf("%s_rdata_wb", tag), Read_Data_WB, v.e_rdata);
    chk($sformatf("%s_mtr_wb", tag), 32'(MemToReg_WB), 32'(v.mtr));
    chk($sformatf("%s_rw_wb", tag), 32'(RegWrite_WB), 32'(v.e_rw));
    chk($sformatf("%s_wr_wb", tag), 32'(Write_register_WB), 32'(v.wr));
    chk($sformatf("%s_mem_err", tag), 32'(mem_error), 32'(v.e_merr));
    chk($sformatf("%s_align_err", tag), 32'(align_error), 32'(v.e_aerr));
    if (v.e_acc > 0) chk($sformatf("%s_addr_hold", tag), mem_addr, v.alu);
    sticky_merr = v.e_merr;
    sticky_aerr = v.e_aerr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t noop, v;
    logic [31:0] orv;
    noop = '{32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0, 32'h0,
             0, 0, 32'h0, 1'b0, 1'b0, 1'b0};
    //          alu            wd             mr    mw    mtr   rw    wr     lat rd             st  acc e_rdata        e_rw  merr  aerr
    tbl[0] = '{32'h0000_0010, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  0,  32'h0,         0,  0,  32'h0,         1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0100, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  3,  32'hDEADBEEF,  4,  3,  32'hDEADBEEF,  1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0104, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1,  32'hFFFF0000,  2,  1,  32'h0,         1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_ABCD, 32'h1,        1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 0,  32'h0,         0,  0,  32'h0,         1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0200, 32'h55AA,     1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  2,  32'hFFFFFFFF,  3,  2,  32'h0,         1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_0108, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 16, 32'hCAFEF00D,  17, 16, 32'hCAFEF00D,  1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h0000_0102, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 2,  32'h00001111,  1,  0,  32'h0,         1'b0, 1'b0, 1'b1};
    tbl[7] = '{32'h0000_010C, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 0,  32'h00002222,  17, 16, 32'h0,         1'b1, 1'b1, 1'b1};
    //          beq   bne   zero  jmp   pc    j
    btbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    btbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    btbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    btbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    btbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    btbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    btbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    btbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    BranchEQ_MEM = 1'b0; BranchNE_MEM = 1'b0; Jump_MEM = 1'b0; Zero_MEM = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset held 3 cycles with an ALU op presented.
    reset = 1'b1;
    drive(tbl[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      orv = mem_addr | mem_wdata | Read_Data_WB | ALU_result_WB |
            {25'h0, Write_register_WB, mem_req, mem_we} |
            {28'h0, MemToReg_WB, RegWrite_WB, mem_error, align_error};
      chk($sformatf("reset_zero_%0d", i), orv, 32'h0);
      chk($sformatf("reset_stall_%0d", i), 32'(Stall_MEM), 32'd0);
    end
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 8; i++) run_instr(tbl[i], $sformatf("vec%0d", i));
    drive(noop);

    // Branch resolution table, FSM idle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      BranchEQ_MEM = btbl[i].beq; BranchNE_MEM = btbl[i].bne;
      Zero_MEM = btbl[i].zero; Jump_MEM = btbl[i].jmp;
      #1;
      chk($sformatf("br%0d_pcsrc", i), 32'(PCSrc_MEM), 32'(btbl[i].e_pc));
      chk($sformatf("br%0d_jump", i), 32'(Jump_taken_MEM), 32'(btbl[i].e_j));
    end
    BranchEQ_MEM = 1'b0; BranchNE_MEM = 1'b0; Jump_MEM = 1'b0; Zero_MEM = 1'b0;

    // Reset asserted in the middle of an ACCESS, then a late ack.
    @(posedge clk); #1;
    v = tbl[1]; v.alu = 32'h300;
    drive(v);
    @(posedge clk); #1;
    chk("midrst_req_up", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(noop);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(Stall_MEM), 32'd0);
    chk("midrst_errs", {30'h0, mem_error, align_error}, 32'h0);
    chk("midrst_rw_wb", 32'(RegWrite_WB), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_err", 32'(mem_error), 32'd0);
    chk("late_ack_rdata", Read_Data_WB, 32'h0);
    chk("late_ack_alu", ALU_result_WB, 32'h77);
    sticky_merr = 1'b0;
    sticky_aerr = 1'b0;

    // Randomized instructions against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      v.mr  = (kind == 1) || (kind == 3);
      v.mw  = (kind >= 2);
      v.alu = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) v.alu = v.alu | 32'($urandom_range(1, 3));
      v.wd  = $urandom;
      v.mtr = 1'($urandom_range(0, 1));
      v.rw  = 1'($urandom_range(0, 1));
      v.wr  = 5'($urandom_range(0, 31));
      v.lat = $urandom_range(0, 18);
      v.rd  = $urandom;
      v = model(v);
      run_instr(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
